// File: rtl/nice_pkg.sv
// Shared types and constants for the NICE response ordering unit.
// Optional feature macro used by the top: NICE_RSP_REG_EN.
package nice_pkg;

    // Write-back source identifiers; higher indices are reserved for future units.
    typedef enum logic [0:0] {
        SRC_CSR = 1'b0,
        SRC_MMA = 1'b1
    } src_id_e;

    // Default memory-access mask: only the MMA unit touches memory.
    localparam logic [1:0] MEM_SRC_MASK_DEFAULT = 2'b10;

    // Default response data width (E203_XLEN).
    localparam int RSP_DW_DEFAULT = 32;

    // One response beat as returned to the core.
    typedef struct packed {
        logic [RSP_DW_DEFAULT-1:0] data;
        logic                      err;
    } rsp_t;

endpackage

// File: rtl/nice_tag_fifo.sv
// Synchronous FIFO of source tags with an occupancy count.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module nice_tag_fifo
    import nice_pkg::*;
#(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is ignored even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Tag storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/nice_rsp_order_unit.sv
// NICE write-back merge and in-order retire unit.
// Results from NUM_SRC execution sources are returned on the nice_rsp_*
// channel in issue order, steered by a FIFO of outstanding source tags.
// Optional macro NICE_RSP_REG_EN adds a 2-entry skid register on the response.
module nice_rsp_order_unit
    import nice_pkg::*;
#(
    parameter  int                 NUM_SRC      = 2,
    parameter  int                 DW           = 32,
    parameter  int                 OUTS_DEPTH   = 4,
    parameter  logic [NUM_SRC-1:0] MEM_SRC_MASK = NUM_SRC'(MEM_SRC_MASK_DEFAULT),
    localparam int                 SRC_W        = $clog2(NUM_SRC),
    localparam int                 CNT_W        = $clog2(OUTS_DEPTH) + 1
) (
    input  logic                  nice_clk,
    input  logic                  nice_rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [SRC_W-1:0]      issue_src,
    input  logic [NUM_SRC-1:0]    src_wb_valid,
    output logic [NUM_SRC-1:0]    src_wb_ready,
    input  logic [NUM_SRC*DW-1:0] src_wb_data,
    input  logic [NUM_SRC-1:0]    src_wb_err,
    output logic                  nice_rsp_valid,
    input  logic                  nice_rsp_ready,
    output logic [DW-1:0]         nice_rsp_rdat,
    output logic                  nice_rsp_err,
    output logic                  nice_mem_holdup,
    output logic                  nice_active,
    output logic [CNT_W-1:0]      outs_cnt
);

    // Memory counter covers the tag FIFO plus up to two skid entries.
    localparam int                 MEM_W     = $clog2(OUTS_DEPTH + 2) + 1;
    localparam logic [SRC_W:0]     NUM_SRC_V = (SRC_W + 1)'(NUM_SRC);

    logic             fifo_full;
    logic             fifo_empty;
    logic [SRC_W-1:0] head_tag;
    logic             head_in_range;
    logic             head_valid;
    logic [DW-1:0]    head_data;
    logic             head_err;
    logic             head_mem;
    logic             head_accept;
    logic             issue_mem;
    logic             push;
    logic             pop;
    logic             deq;
    logic             deq_mem;
    logic [MEM_W-1:0] mem_cnt_q;

    assign issue_ready   = ~fifo_full;
    assign push          = issue_valid & ~fifo_full;
    assign head_in_range = ({1'b0, head_tag} < NUM_SRC_V);

    nice_tag_fifo #(
        .W     (SRC_W),
        .DEPTH (OUTS_DEPTH)
    ) u_tag_fifo (
        .clk_i   (nice_clk),
        .rst_ni  (nice_rst_n),
        .push_i  (push),
        .din_i   (issue_src),
        .pop_i   (pop),
        .dout_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (outs_cnt)
    );

    // Select the head source's write-back; an out-of-range tag retires as an error with zero data.
    always_comb begin
        head_valid = 1'b0;
        head_data  = '0;
        head_err   = 1'b0;
        head_mem   = 1'b0;
        issue_mem  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (head_tag == SRC_W'(i)) begin
                head_valid = src_wb_valid[i];
                head_data  = src_wb_data[i*DW +: DW];
                head_err   = src_wb_err[i];
                head_mem   = MEM_SRC_MASK[i];
            end
            if (issue_src == SRC_W'(i)) begin
                issue_mem = MEM_SRC_MASK[i];
            end
        end
        if (!head_in_range) begin
            head_valid = 1'b1;
            head_err   = 1'b1;
        end
        if (fifo_empty) begin
            head_valid = 1'b0;
            head_data  = '0;
            head_err   = 1'b0;
            head_mem   = 1'b0;
        end
    end

    // Only the head source sees ready; every other source is stalled.
    always_comb begin
        src_wb_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!fifo_empty && (head_tag == SRC_W'(i))) begin
                src_wb_ready[i] = head_accept;
            end
        end
    end

    assign pop = head_valid & head_accept;

`ifdef NICE_RSP_REG_EN
    // Two-entry skid: head results are captured here and popped from the tag FIFO on capture.
    logic [DW-1:0] sk_data_q [2];
    logic [1:0]    sk_err_q;
    logic [1:0]    sk_mem_q;
    logic          sk_wr_q;
    logic          sk_rd_q;
    logic [1:0]    sk_cnt_q;

    assign head_accept    = (sk_cnt_q != 2'd2);
    assign nice_rsp_valid = (sk_cnt_q != 2'd0);
    assign nice_rsp_rdat  = sk_data_q[sk_rd_q];
    assign nice_rsp_err   = sk_err_q[sk_rd_q];
    assign deq            = nice_rsp_valid & nice_rsp_ready;
    assign deq_mem        = sk_mem_q[sk_rd_q];

    // Skid storage and occupancy.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            sk_data_q[0] <= '0;
            sk_data_q[1] <= '0;
            sk_err_q     <= '0;
            sk_mem_q     <= '0;
            sk_wr_q      <= 1'b0;
            sk_rd_q      <= 1'b0;
            sk_cnt_q     <= 2'd0;
        end else begin
            if (pop) begin
                sk_data_q[sk_wr_q] <= head_data;
                sk_err_q[sk_wr_q]  <= head_err;
                sk_mem_q[sk_wr_q]  <= head_mem;
                sk_wr_q            <= ~sk_wr_q;
            end
            if (deq) begin
                sk_rd_q <= ~sk_rd_q;
            end
            case ({pop, deq})
                2'b10:   sk_cnt_q <= sk_cnt_q + 2'd1;
                2'b01:   sk_cnt_q <= sk_cnt_q - 2'd1;
                default: sk_cnt_q <= sk_cnt_q;
            endcase
        end
    end
`else
    // Combinational pass-through: the head write-back drives the response directly.
    assign head_accept    = nice_rsp_ready;
    assign nice_rsp_valid = head_valid;
    assign nice_rsp_rdat  = head_data;
    assign nice_rsp_err   = head_err;
    assign deq            = pop;
    assign deq_mem        = head_mem;
`endif

    // Count memory-source instructions from issue until their response handshake.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            mem_cnt_q <= '0;
        end else begin
            case ({push & issue_mem, deq & deq_mem})
                2'b10:   mem_cnt_q <= mem_cnt_q + MEM_W'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - MEM_W'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
        end
    end

    assign nice_mem_holdup = (mem_cnt_q != '0);
    assign nice_active     = ~fifo_empty | nice_rsp_valid;

endmodule

// File: doc/nice_rsp_order_unit.md
Name: nice_rsp_order_unit

Overview:
Parametrised successor to the NICE core write-back path. It merges the write-back unit and the instruction-retire tracker into one block.
- Accepts write-back results from NUM_SRC execution sources (CSR unit, MMA, future units).
- Returns them on the NICE response channel strictly in instruction-issue order, using an outstanding-instruction source-tag FIFO.
- Sits between decode/dispatch, the execution units and the nice_rsp_* / nice_mem_holdup / nice_active core outputs.

Parameters:
NUM_SRC, 2, number of write-back sources (index 0 = CSR unit, 1 = MMA); must be >= 2
DW, 32, response data width (E203_XLEN)
OUTS_DEPTH, 4, maximum outstanding issued-but-unretired instructions; power of 2, >= 2
MEM_SRC_MASK, 2'b10, bit i set = source i accesses memory and contributes to nice_mem_holdup
SRC_W (localparam), $clog2(NUM_SRC), source-tag width

Ports:
nice_clk  in  1  clock
nice_rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  dispatch has issued an instruction to a source
issue_ready  out  1  tag FIFO can accept an issue
issue_src  in  SRC_W  destination source of the issued instruction
src_wb_valid  in  NUM_SRC  per-source write-back valid
src_wb_ready  out  NUM_SRC  per-source write-back ready
src_wb_data  in  NUM_SRC*DW  per-source data, source i at [i*DW +: DW]
src_wb_err  in  NUM_SRC  per-source error flag
nice_rsp_valid  out  1  response valid
nice_rsp_ready  in  1  response ready
nice_rsp_rdat  out  DW  response data
nice_rsp_err  out  1  response error
nice_mem_holdup  out  1  a memory-source instruction is outstanding
nice_active  out  1  any instruction outstanding or response pending
outs_cnt  out  $clog2(OUTS_DEPTH)+1  number of outstanding entries

Behaviour:
- Reset (async, nice_rst_n low): FIFO empty, pointers 0, outs_cnt=0, mem counter 0. All outputs 0 except issue_ready=1. Reset mid-operation discards all outstanding entries and any in-flight response.
- Issue: handshake is issue_valid & issue_ready. It pushes issue_src at wr_ptr. issue_ready = !full; there is no same-cycle bypass when full, even if the head retires that cycle. An issue_src >= NUM_SRC is still pushed; its entry retires with data 0 and err=1 when it reaches the head.
- Head: with the FIFO non-empty, h = tag at rd_ptr.
  - src_wb_ready[h] = nice_rsp_ready; all other src_wb_ready = 0, so non-head sources stall.
  - nice_rsp_valid = src_wb_valid[h]; rdat/err are muxed from source h.
  - Retire = nice_rsp_valid & nice_rsp_ready; it pops the FIFO.
  - With the FIFO empty, all src_wb_ready=0 and nice_rsp_valid=0. A valid arriving while the FIFO is empty is held off, not dropped.
- Latency: combinational pass-through by default, 0 cycles from head src_wb_valid to nice_rsp_valid. An instruction issued in cycle t can retire at the earliest in cycle t+1; no issue-to-retire bypass.
- Simultaneous push and pop: outs_cnt unchanged, both pointers advance. Pointers wrap modulo OUTS_DEPTH. full = (outs_cnt==OUTS_DEPTH), empty = (outs_cnt==0).
- mem_cnt: +1 on issue of a source with MEM_SRC_MASK bit set, -1 on retire of such a source; +1 and -1 in the same cycle net to 0. nice_mem_holdup = (mem_cnt!=0).
- nice_active = !empty | nice_rsp_valid.
- Data from a source is stable only while its valid is held. The unit never stores write-back data except with the optional register enabled.

Optional Feature:
Macro NICE_RSP_REG_EN.
- Defined: a 2-entry skid register sits on the response path.
  - nice_rsp_* are driven from flops; latency is 1 cycle from the head write-back handshake.
  - src_wb_ready[h] = skid not full.
  - Pop occurs when the head write-back is captured into the skid. nice_mem_holdup and nice_active also count skid occupancy until the response handshake completes.
  - Full throughput, 1 response/cycle, under continuous nice_rsp_ready.
- Undefined: combinational path exactly as in Behaviour.

Decomposition:
- Shared package nice_pkg holds:
  - the src_id_e enum (SRC_CSR=0, SRC_MMA=1);
  - the default MEM_SRC_MASK constant;
  - the rsp_t struct {data, err}.
- One sub-module, nice_tag_fifo: a parametrised sync FIFO of SRC_W-bit tags with a count output. The skid register stays inline under the macro.

Test Plan:
- Order: issue MMA then CSR. CSR wb 0x11 valid first, MMA wb 0xAA 3 cycles later -> CSR held (ready=0); rsp sequence 0xAA then 0x11; outs_cnt 2->1->0.
- Full: OUTS_DEPTH=4, issue 5 back-to-back with no wb -> issue_ready=0 after the 4th. Retire one with issue_valid high -> 5th accepted the following cycle, not the same cycle.
- Holdup: issue MMA, CSR, MMA -> nice_mem_holdup=1 until the second MMA retires. With issue MMA and retire MMA in the same cycle at mem_cnt=1 -> holdup stays 1.
- Backpressure: nice_rsp_ready=0 for 5 cycles with head valid -> rdat/err stable, src_wb_ready[h]=0, no pop.
- Error/stray: src_wb_err=1 on the head -> nice_rsp_err=1. CSR valid with FIFO empty -> no response, ready=0. Issue of out-of-range src -> rsp rdat=0, err=1.
- Reset: nice_rst_n low with 3 outstanding -> next cycle outs_cnt=0, holdup=0, nice_active=0, issue_ready=1. With NICE_RSP_REG_EN, verify 1-cycle latency and back-to-back throughput of 4 responses.
